// File: rtl/pattern_stream_tx_if.sv
// Word-in / bit-out bundle for pattern_stream_tx: a valid/ready word input
// plus the serial stream and its 101-match bookkeeping outputs.
interface pattern_stream_tx_if #(
    parameter int WORD_W = 8
);
    localparam int CNT_W = $clog2(WORD_W) + 1;

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_bit;
    logic              ser_valid;
    logic [2:0]        pattern;
    logic [CNT_W-1:0]  match_count;
    logic              word_done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_bit,
        input  ser_valid,
        input  pattern,
        input  match_count,
        input  word_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_bit,
        output ser_valid,
        output pattern,
        output match_count,
        output word_done
    );
endinterface

// File: rtl/pattern_stream_tx.sv
// Serialises accepted words MSB-first onto a one-bit stream and counts the
// overlapping "101" occurrences seen in the word as it goes out.
module pattern_stream_tx #(
    parameter int WORD_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    pattern_stream_tx_if.slave bus
);
    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam int BC_W  = $clog2(WORD_W);
    localparam int GC_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_W - 1);
    localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GC_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [2:0]        pattern_q, pattern_d;
    logic [CNT_W-1:0]  match_count_q, match_count_d;
    logic              in_ready_q, in_ready_d;
    logic              word_done_q, word_done_d;
    logic              cur_bit;
    logic [2:0]        window;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        pattern_d     = pattern_q;
        match_count_d = match_count_q;
        word_done_d   = 1'b0;
        cur_bit       = (state_q == SHIFT) && shreg_q[WORD_W-1];
        window        = {pattern_q[1:0], cur_bit};

        case (state_q)
            IDLE: begin
                // in_ready_q is only ever high in IDLE, so it alone qualifies the handshake
                if (bus.in_valid && in_ready_q) begin
                    shreg_d       = bus.in_data;
                    bit_cnt_d     = '0;
                    pattern_d     = '0;
                    match_count_d = '0;
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                pattern_d = window;
                if (window == 3'b101) begin
                    match_count_d = match_count_q + CNT_W'(1);
                end
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BIT_LAST) begin
                    word_done_d = 1'b1;
                    gap_cnt_d   = '0;
                    state_d     = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + GC_W'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready: high in exactly the cycles the FSM sits in IDLE
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            pattern_q     <= '0;
            match_count_q <= '0;
            in_ready_q    <= 1'b0;
            word_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            pattern_q     <= pattern_d;
            match_count_q <= match_count_d;
            in_ready_q    <= in_ready_d;
            word_done_q   <= word_done_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.ser_valid   = (state_q == SHIFT);
    assign bus.ser_bit     = cur_bit;
    assign bus.pattern     = pattern_q;
    assign bus.match_count = match_count_q;
    assign bus.word_done   = word_done_q;

endmodule

// File: tb/tb_pattern_stream_tx.sv
// Bench for pattern_stream_tx: a timeline model (offset of each cycle from the
// last accepted word) predicts every output; directed words pin literal results.
module tb_pattern_stream_tx;
    localparam int W  = 8;
    localparam int G  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pattern_stream_tx_if #(.WORD_W(W)) bus ();

    pattern_stream_tx #(
        .WORD_W    (W),
        .GAP_CYCLES(G)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Model state: whether a word has been accepted since reset, which word,
    // and how many rising edges have passed since its accept edge.
    logic        m_armed = 1'b0;
    logic        m_have  = 1'b0;
    int          m_d     = 0;
    logic [W-1:0] m_word = '0;

    function automatic logic exp_ready();
        return m_armed && (!m_have || m_d >= W + G);
    endfunction

    function automatic logic bit_at(input logic [W-1:0] w, input int i);
        if (i < 0 || i >= W) return 1'b0;
        return w[W-1-i];
    endfunction

    function automatic logic [2:0] window_of(input logic [W-1:0] w, input int p);
        logic [2:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) r[k] = bit_at(w, p - 1 - k);
        return r;
    endfunction

    function automatic logic [31:0] count101(input logic [W-1:0] w, input int p);
        int n;
        n = 0;
        for (int i = 2; i < p; i++)
            if (bit_at(w, i-2) && !bit_at(w, i-1) && bit_at(w, i)) n++;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_armed <= 1'b0;
            m_have  <= 1'b0;
            m_d     <= 0;
        end else begin
            m_armed <= 1'b1;
            if (exp_ready() && bus.in_valid === 1'b1) begin
                m_have <= 1'b1;
                m_word <= bus.in_data;
                m_d    <= 0;
            end else if (m_have && m_d < 1000) begin
                m_d <= m_d + 1;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        int   p;
        logic sv;
        p  = m_have ? ((m_d < W) ? m_d : W) : 0;
        sv = m_have && (m_d < W);
        check_output("in_ready",    bus.in_ready,    exp_ready());
        check_output("ser_valid",   bus.ser_valid,   sv);
        check_output("ser_bit",     bus.ser_bit,     sv ? bit_at(m_word, m_d) : 1'b0);
        check_output("pattern",     bus.pattern,     window_of(m_word, p));
        check_output("match_count", bus.match_count, count101(m_word, p));
        check_output("word_done",   bus.word_done,   m_have && m_d == W);
    end

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_output(name, (t < 50), 1);
    endtask

    // Send one word (called at a negedge), capture its serial bits, check literals at word_done.
    task automatic send_word(input logic [W-1:0] data, input bit hold, input logic [31:0] exp_cnt, input logic [2:0] exp_pat);
        logic [W-1:0] got;
        int           nbits;
        int           t;
        bit           done;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        wait_ready("accept_timeout");
        @(negedge clk);
        if (!hold) begin
            bus.in_valid = 1'b0;
            bus.in_data  = ~data;
        end
        got   = '0;
        nbits = 0;
        done  = 1'b0;
        t     = 0;
        while (!done && t < 50) begin
            if (bus.ser_valid === 1'b1) begin
                got = {got[W-2:0], bus.ser_bit};
                nbits++;
            end
            if (bus.word_done === 1'b1) done = 1'b1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        check_output("word_done_seen", done, 1);
        check_output("bit_count",      nbits, W);
        check_output("serial_word",    got, data);
        check_output("final_count",    bus.match_count, exp_cnt);
        check_output("final_pattern",  bus.pattern, exp_pat);
    endtask

    task automatic apply_stimulus();
        int low;
        // Reset hold and release
        repeat (3) @(negedge clk);
        check_output("ready_in_reset", bus.in_ready, 0);
        check_output("ser_valid_in_reset", bus.ser_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        check_output("ready_after_release", bus.in_ready, 1);

        send_word(8'b10101010, 1'b0, 3, 3'b010);
        send_word(8'b10100101, 1'b0, 2, 3'b101);
        send_word(8'hFF,       1'b0, 0, 3'b111);
        send_word(8'h00,       1'b0, 0, 3'b000);

        // Back-to-back with in_valid held high
        wait_ready("b2b_first_ready");
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        @(negedge clk);
        low = 0;
        while (bus.in_ready === 1'b0 && low < 40) begin
            low++;
            @(negedge clk);
        end
        check_output("ready_low_run_1", low, W + G);
        bus.in_data = 8'hC3;
        @(negedge clk);
        check_output("count_cleared", bus.match_count, 0);
        low = 0;
        while (bus.in_ready === 1'b0 && low < 40) begin
            low++;
            @(negedge clk);
        end
        check_output("ready_low_run_2", low, W + G);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-word, after four bits have gone out
        wait_ready("midword_ready");
        bus.in_data  = 8'hB7;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_output("midword_busy", bus.ser_valid, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_output("async_ser_valid", bus.ser_valid, 0);
        check_output("async_count",     bus.match_count, 0);
        check_output("async_ready",     bus.in_ready, 0);
        repeat (2) @(negedge clk);
        check_output("no_word_done", bus.word_done, 0);
        reset = 1'b1;
        @(negedge clk);
        send_word(8'b11010110, 1'b0, 2, 3'b110);

        // Randomised traffic, data churning while not ready, rare reset pulses
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = W'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 reset = 1'b0;
        apply_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
